// File: rtl/imem_writer.sv
// Serialises 64-bit program words into little-endian byte writes on the instruction memory write port.
// Optional XOR checksum of written bytes when IMEM_WR_CHECKSUM_EN is defined.
//   state  | meaning
//   IDLE   | waiting for start, no stream handshake
//   ACCEPT | wr_ready high, waiting for the next word
//   WRITE  | one byte per cycle, eight cycles per word
//   DONE   | one-cycle done pulse after a wr_last word
module imem_writer #(
   parameter int MEM_SIZE = 1024,
   parameter int ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [63:0]       base_addr,
   input  logic              wr_valid,
   input  logic [63:0]       wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              imem_error,
   output logic [15:0]       words_written
`ifdef IMEM_WR_CHECKSUM_EN
   ,
   output logic [7:0]        checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [63:0]         ptr_q;
   logic [63:0]         word_q;
   logic                last_q;
   logic [2:0]          idx_q;
   logic                err_q;
   logic [15:0]         cnt_q;
   logic [ADDR_W-1:0]   addr_hold_q;
   logic [7:0]          data_hold_q;
   logic [7:0]          cur_byte;
   logic                in_range;
`ifdef IMEM_WR_CHECKSUM_EN
   logic [7:0]          csum_q;
`endif

   // Full-width compare so a huge pointer can never alias into low memory.
   assign in_range = (ptr_q <= 64'(MEM_SIZE - 1));
   assign cur_byte = word_q[{idx_q, 3'b000} +: 8];

   always_comb begin
      state_d  = state_q;
      wr_ready = 1'b0;
      mem_we   = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = ACCEPT;
         end
         ACCEPT: begin
            wr_ready = 1'b1;
            if (wr_valid) state_d = WRITE;
         end
         WRITE: begin
            if (in_range) begin
               mem_we = 1'b1;
               if (idx_q == 3'd7) state_d = last_q ? DONE : ACCEPT;
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr      = mem_we ? ptr_q[ADDR_W-1:0] : addr_hold_q;
   assign mem_wdata     = mem_we ? cur_byte : data_hold_q;
   assign busy          = (state_q != IDLE);
   assign imem_error    = err_q;
   assign words_written = cnt_q;
`ifdef IMEM_WR_CHECKSUM_EN
   assign checksum      = csum_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 64'd0;
         word_q      <= 64'd0;
         last_q      <= 1'b0;
         idx_q       <= 3'd0;
         err_q       <= 1'b0;
         cnt_q       <= 16'd0;
         addr_hold_q <= '0;
         data_hold_q <= 8'd0;
`ifdef IMEM_WR_CHECKSUM_EN
         csum_q      <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  ptr_q <= base_addr;
                  err_q <= 1'b0;
                  cnt_q <= 16'd0;
`ifdef IMEM_WR_CHECKSUM_EN
                  csum_q <= 8'd0;
`endif
               end
            end
            ACCEPT: begin
               if (wr_valid) begin
                  word_q <= wr_data;
                  last_q <= wr_last;
                  idx_q  <= 3'd0;
               end
            end
            WRITE: begin
               if (in_range) begin
                  ptr_q       <= ptr_q + 64'd1;
                  idx_q       <= idx_q + 3'd1;
                  addr_hold_q <= ptr_q[ADDR_W-1:0];
                  data_hold_q <= cur_byte;
`ifdef IMEM_WR_CHECKSUM_EN
                  csum_q      <= csum_q ^ cur_byte;
`endif
                  if (idx_q == 3'd7 && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
               end else begin
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_writer.sv
// Bench for imem_writer: directed and randomized load sessions checked against a byte-stream model.
// Build with IMEM_WR_CHECKSUM_EN defined to also exercise the checksum output.
module tb_imem_writer;
   localparam int MEM_SIZE = 1024;
   localparam int ADDR_W   = 10;

   logic              clk = 1'b0;
   logic              reset, start, wr_valid, wr_last;
   logic [63:0]       base_addr, wr_data;
   logic              wr_ready, mem_we, busy, done, imem_error;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [15:0]       words_written;
`ifdef IMEM_WR_CHECKSUM_EN
   logic [7:0]        checksum;
`endif

   imem_writer #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
      .wr_ready(wr_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .imem_error(imem_error), .words_written(words_written)
`ifdef IMEM_WR_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [ADDR_W-1:0] obs_addr[$];
   logic [7:0]        obs_data[$];
   int                obs_cyc[$];
   int                acc_cyc[$];
   int                done_cnt, done_cyc, ready_cnt;
   logic [63:0]       tx_words[8];

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_addr.push_back(mem_addr);
         obs_data.push_back(mem_wdata);
         obs_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (wr_ready === 1'b1 && wr_valid === 1'b1) acc_cyc.push_back(cyc);
      if (wr_ready === 1'b1) ready_cnt++;
   end

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
      obs_cyc.delete();
      acc_cyc.delete();
      done_cnt  = 0;
      done_cyc  = 0;
      ready_cnt = 0;
   endtask

   // Model: a session is the flat byte stream base, base+1, ... that stops at the first byte beyond memory.
   task automatic run_session(input string tag, input logic [63:0] base, input int n,
                              input bit hold, input bit poke);
      logic [63:0] exp_addr[$];
      logic [7:0]  exp_data[$];
      logic [63:0] a;
      logic [7:0]  xs;
      bit          err;
      int          full, n_acc, t;
      err = 0; full = 0; n_acc = n; xs = 8'd0;
      for (int w = 0; w < n && !err; w++) begin
         for (int b = 0; b < 8; b++) begin
            a = base + 64'(w * 8 + b);
            if (a > 64'(MEM_SIZE - 1)) begin
               err = 1;
               n_acc = w + 1;
               break;
            end
            exp_addr.push_back(a);
            exp_data.push_back(8'(tx_words[w] >> (8 * b)));
            xs = xs ^ 8'(tx_words[w] >> (8 * b));
         end
         if (!err) full++;
      end

      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; base_addr = base;
      @(posedge clk); #1;
      start = 1'b0; base_addr = {$urandom, $urandom};
      wr_valid = 1'b1; wr_data = tx_words[0]; wr_last = (n == 1);
      @(negedge clk);
      checks++;
      if (imem_error !== 1'b0 || words_written !== 16'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s start_state err=%b words=%0d busy=%b want 0 0 1", tag, imem_error, words_written, busy);
      end
      for (int w = 0; w < n_acc; w++) begin
         if (w > 0) @(negedge clk);
         t = 0;
         while (wr_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
         end
         if (wr_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s accept_timeout word=%0d ready=%b want 1", tag, w, wr_ready);
            break;
         end
         @(posedge clk); #1;
         if (poke && w == 0) begin
            start = 1'b1; base_addr = 64'h0;
            @(posedge clk); #1;
            start = 1'b0;
         end
         if (w + 1 < n_acc) begin
            if (!hold) begin
               wr_valid = 1'b0;
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            wr_valid = 1'b1; wr_data = tx_words[w+1]; wr_last = (w + 1 == n - 1);
         end else begin
            wr_valid = 1'b0; wr_last = 1'b0;
         end
      end
      t = 0;
      @(negedge clk);
      while (busy === 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end

      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s end_timeout busy=%b want 0", tag, busy);
      end
      checks++;
      if (obs_addr.size() != exp_addr.size()) begin
         errors++;
         $display("FAIL %s write_count got %0d want %0d", tag, obs_addr.size(), exp_addr.size());
      end else begin
         for (int i = 0; i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i][ADDR_W-1:0] || obs_data[i] !== exp_data[i]) begin
               errors++;
               $display("FAIL %s byte%0d got addr=%h data=%h want addr=%h data=%h", tag, i,
                        obs_addr[i], obs_data[i], exp_addr[i][ADDR_W-1:0], exp_data[i]);
            end
         end
      end
      checks++;
      if (acc_cyc.size() != n_acc) begin
         errors++;
         $display("FAIL %s accept_count got %0d want %0d", tag, acc_cyc.size(), n_acc);
      end
      checks++;
      if (done_cnt != (err ? 0 : 1)) begin
         errors++;
         $display("FAIL %s done_count got %0d want %0d", tag, done_cnt, err ? 0 : 1);
      end
      checks++;
      if (words_written !== 16'(full) || imem_error !== err) begin
         errors++;
         $display("FAIL %s result words=%0d err=%b want words=%0d err=%b", tag, words_written, imem_error, full, err);
      end
      if (exp_addr.size() > 0) begin
         checks++;
         if (mem_addr !== exp_addr[exp_addr.size()-1][ADDR_W-1:0] || mem_wdata !== exp_data[exp_data.size()-1]) begin
            errors++;
            $display("FAIL %s hold got addr=%h data=%h want addr=%h data=%h", tag, mem_addr, mem_wdata,
                     exp_addr[exp_addr.size()-1][ADDR_W-1:0], exp_data[exp_data.size()-1]);
         end
      end
      if (hold && !err && acc_cyc.size() == n && obs_cyc.size() == 8 * n) begin
         checks++;
         if (ready_cnt != n) begin
            errors++;
            $display("FAIL %s ready_cycles got %0d want %0d", tag, ready_cnt, n);
         end
         for (int i = 0; i < 8 * n; i++) begin
            checks++;
            if (obs_cyc[i] != acc_cyc[i/8] + 1 + (i % 8)) begin
               errors++;
               $display("FAIL %s byte_timing%0d got cyc %0d want %0d", tag, i, obs_cyc[i], acc_cyc[i/8] + 1 + (i % 8));
            end
         end
         checks++;
         if (done_cyc != obs_cyc[8*n-1] + 1) begin
            errors++;
            $display("FAIL %s done_timing got cyc %0d want %0d", tag, done_cyc, obs_cyc[8*n-1] + 1);
         end
      end
`ifdef IMEM_WR_CHECKSUM_EN
      checks++;
      if (checksum !== xs) begin
         errors++;
         $display("FAIL %s checksum got %h want %h", tag, checksum, xs);
      end
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (wr_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || imem_error !== 1'b0 ||
          mem_addr !== '0 || mem_wdata !== 8'd0 || words_written !== 16'd0) begin
         errors++;
         $display("FAIL %s outputs rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h words=%0d want all 0",
                  tag, wr_ready, mem_we, busy, done, imem_error, mem_addr, mem_wdata, words_written);
      end
`ifdef IMEM_WR_CHECKSUM_EN
      checks++;
      if (checksum !== 8'd0) begin
         errors++;
         $display("FAIL %s checksum got %h want 00", tag, checksum);
      end
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; wr_valid = 1'b1; wr_last = 1'b1;
      base_addr = {$urandom, $urandom}; wr_data = {$urandom, $urandom};
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset_held");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_released");
   endtask

   task automatic test_single_word();
      tx_words[0] = 64'h0123456789ABCDEF;
      run_session("single", 64'h0, 1, 1'b1, 1'b0);
      checks++;
      if (obs_data.size() != 8 || obs_data[0] !== 8'hEF || obs_data[7] !== 8'h01) begin
         errors++;
         $display("FAIL single endian size=%0d want first EF last 01", obs_data.size());
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) tx_words[i] = {$urandom, $urandom};
      run_session("b2b", 64'h100, 3, 1'b1, 1'b0);
   endtask

   task automatic test_range_error();
      tx_words[0] = {$urandom, $urandom};
      run_session("range_1020", 64'd1020, 1, 1'b1, 1'b0);
      run_session("range_1023", 64'd1023, 1, 1'b1, 1'b0);
      run_session("range_1024", 64'd1024, 1, 1'b1, 1'b0);
      run_session("range_huge", 64'hFFFF_FFFF_FFFF_FFF8, 1, 1'b1, 1'b0);
      tx_words[1] = {$urandom, $urandom};
      run_session("range_cross", 64'd1012, 2, 1'b0, 1'b0);
      run_session("range_clear", 64'd0, 1, 1'b1, 1'b0);
   endtask

   task automatic test_start_ignored();
      tx_words[0] = {$urandom, $urandom};
      tx_words[1] = {$urandom, $urandom};
      run_session("start_in_write", 64'h200, 2, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_word();
      logic [63:0] w;
      w = {$urandom, $urandom};
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 64'h40;
      @(posedge clk); #1;
      start = 1'b0; wr_valid = 1'b1; wr_data = w; wr_last = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_last = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset_mid");
      repeat (10) @(negedge clk);
      checks++;
      if (obs_addr.size() != 4 || done_cnt != 0) begin
         errors++;
         $display("FAIL reset_mid writes=%0d done=%0d want 4 0", obs_addr.size(), done_cnt);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== ADDR_W'(64 + i) || obs_data[i] !== 8'(w >> (8 * i))) begin
               errors++;
               $display("FAIL reset_mid byte%0d got addr=%h data=%h want addr=%h data=%h", i,
                        obs_addr[i], obs_data[i], ADDR_W'(64 + i), 8'(w >> (8 * i)));
            end
         end
      end
   endtask

   task automatic test_checksum();
      tx_words[0] = 64'h00000000000000FF;
      tx_words[1] = 64'h0000000000000001;
      run_session("checksum", 64'h0, 2, 1'b1, 1'b0);
`ifdef IMEM_WR_CHECKSUM_EN
      checks++;
      if (checksum !== 8'hFE) begin
         errors++;
         $display("FAIL checksum_fe got %h want fe", checksum);
      end
`endif
   endtask

   task automatic test_random();
      logic [63:0] base;
      int          n;
      for (int s = 0; s < 10; s++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) tx_words[i] = {$urandom, $urandom};
         case ($urandom_range(0, 2))
            0:       base = 64'($urandom_range(0, MEM_SIZE - 33));
            1:       base = 64'(MEM_SIZE - $urandom_range(1, 40));
            default: base = 64'($urandom_range(MEM_SIZE, MEM_SIZE + 80));
         endcase
         run_session("random", base, n, 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      base_addr = 64'd0; wr_data = 64'd0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_range_error();
      test_start_ignored();
      test_reset_mid_word();
      test_checksum();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
